// File: rtl/simt_pc.sv
// simt_pc: per-core program counter with branch-divergence support.
//
// Holds one PC shared by all lanes, a per-lane NZP flag register and an
// active-lane mask. Divergent BRnzp branches run the taken lanes first, then
// the not-taken lanes, then reconverge; each path ends with a SYNC that pops
// one entry from the reconvergence stack.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     core active; state holds when low
//   core_state                 core FSM state (EXECUTE=101, UPDATE=110)
//   thread_enable              lanes populated in the current block
//   decoded_nzp                branch condition mask
//   decoded_immediate          branch target
//   decoded_pc_mux             instruction is BRnzp
//   decoded_sync               instruction is SYNC
//   decoded_nzp_write_enable   instruction is CMP
//   alu_out                    per-lane ALU results; bits [2:0] of each are N,Z,P
//   next_pc                    PC of the next instruction
//   active_mask                mask_reg & thread_enable
//   stack_depth                occupied reconvergence stack entries
//   stack_overflow             sticky: a divergence found no room on the stack
module simt_pc #(
    parameter int unsigned THREADS               = 4,
    parameter int unsigned DATA_MEM_DATA_BITS    = 16,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned STACK_DEPTH           = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [2:0]                             core_state,
    input  logic [THREADS-1:0]                     thread_enable,
    input  logic [2:0]                             decoded_nzp,
    input  logic [7:0]                             decoded_immediate,
    input  logic                                   decoded_pc_mux,
    input  logic                                   decoded_sync,
    input  logic                                   decoded_nzp_write_enable,
    input  logic [THREADS*DATA_MEM_DATA_BITS-1:0]  alu_out,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]       next_pc,
    output logic [THREADS-1:0]                     active_mask,
    output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_depth,
    output logic                                   stack_overflow
);

    localparam int unsigned AW     = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned W      = DATA_MEM_DATA_BITS;
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW   = $clog2(STACK_DEPTH);

    localparam logic [2:0] EXECUTE = 3'b101;
    localparam logic [2:0] UPDATE  = 3'b110;

    typedef enum logic {EntElse, EntReconv} entry_e;

    logic [AW-1:0]      pc_q, pc_d, pc_inc, imm_pc;
    logic [THREADS-1:0] mask_q, mask_d, take;
    logic [2:0]         nzp_q [THREADS];
    logic [2:0]         nzp_d [THREADS];
    logic [DepthW-1:0]  depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               push, divergent, has_room, stack_empty;
    logic [IdxW-1:0]    push_idx, push_idx_hi, top_idx;

    entry_e             stk_type [STACK_DEPTH];
    logic [AW-1:0]      stk_pc   [STACK_DEPTH];
    logic [THREADS-1:0] stk_mask [STACK_DEPTH];

    // Only the NZP bits of each lane's ALU result are consumed.
    logic unused_alu;
    assign unused_alu = ^alu_out;

    assign active_mask    = mask_q & thread_enable;
    assign next_pc        = pc_q;
    assign stack_depth    = depth_q;
    assign stack_overflow = ovf_q;

    assign pc_inc      = pc_q + 1'b1;
    assign imm_pc      = AW'(decoded_immediate);
    assign has_room    = depth_q <= DepthW'(STACK_DEPTH - 2);
    assign stack_empty = depth_q == '0;
    assign push_idx    = IdxW'(depth_q);
    assign push_idx_hi = push_idx + 1'b1;
    assign top_idx     = IdxW'(depth_q - 1'b1);

    always_comb begin
        take = '0;
        for (int t = 0; t < THREADS; t++) begin
            take[t] = active_mask[t] & (|(nzp_q[t] & decoded_nzp));
        end
    end

    // Non-zero take that differs from the active set means lanes disagree.
    assign divergent = (take != '0) && (take != active_mask);

    always_comb begin
        pc_d    = pc_q;
        mask_d  = mask_q;
        nzp_d   = nzp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        if (enable) begin
            if (core_state == UPDATE) begin
                if (decoded_nzp_write_enable) begin
                    for (int t = 0; t < THREADS; t++) begin
                        if (active_mask[t]) nzp_d[t] = alu_out[t*W +: 3];
                    end
                end
            end else if (core_state == EXECUTE) begin
                if (decoded_pc_mux) begin
                    // pc_mux wins over a simultaneous sync.
                    if (!divergent) begin
                        pc_d = (take != '0) ? imm_pc : pc_inc;
                    end else if (has_room) begin
                        push    = 1'b1;
                        mask_d  = take;
                        pc_d    = imm_pc;
                        depth_d = depth_q + DepthW'(2);
                    end else begin
                        ovf_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (decoded_sync && !stack_empty) begin
                    depth_d = depth_q - 1'b1;
                    mask_d  = stk_mask[top_idx];
                    pc_d    = (stk_type[top_idx] == EntElse) ? stk_pc[top_idx] : pc_inc;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            mask_q  <= '1;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            for (int t = 0; t < THREADS; t++) nzp_q[t] <= 3'b000;
        end else begin
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            nzp_q   <= nzp_d;
        end
    end

    // Reconvergence entry goes below the else entry so the else path is
    // popped first and the full mask is restored last.
    always_ff @(posedge clk) begin
        if (push) begin
            stk_type[push_idx]    <= EntReconv;
            stk_pc[push_idx]      <= pc_q;
            stk_mask[push_idx]    <= active_mask;
            stk_type[push_idx_hi] <= EntElse;
            stk_pc[push_idx_hi]   <= pc_inc;
            stk_mask[push_idx_hi] <= active_mask & ~take;
        end
    end

endmodule

// File: doc/simt_pc.md
Name: simt_pc

Overview:
- Per-core program counter unit with branch-divergence support; the next generation of the per-thread PC logic.
- Holds one shared PC, a per-thread NZP register and an active-thread mask for THREADS lanes.
- Divergent BRnzp branches are serialised through a reconvergence stack and merged again by a SYNC instruction.
- Sits between the decoder/ALUs and the fetcher/scheduler; the scheduler fetches from next_pc and gates lane writes with active_mask.

Parameters:
- THREADS, 4, lanes per core.
- DATA_MEM_DATA_BITS, 16, per-lane ALU result width (Q1.15).
- PROGRAM_MEM_ADDR_BITS, 8, program address width.
- STACK_DEPTH, 8, reconvergence stack entries. Must be even and ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  core active; when low, all state holds.
- core_state  in  3  core FSM state: EXECUTE=3'b101, UPDATE=3'b110.
- thread_enable  in  THREADS  lanes populated in the current block.
- decoded_nzp  in  3  branch condition mask.
- decoded_immediate  in  8  branch target; low PROGRAM_MEM_ADDR_BITS bits are used.
- decoded_pc_mux  in  1  current instruction is BRnzp.
- decoded_sync  in  1  current instruction is SYNC (reconverge).
- decoded_nzp_write_enable  in  1  current instruction is CMP.
- alu_out  in  THREADS*DATA_MEM_DATA_BITS  lane t occupies slice [t*W +: W]; bits [2:0] of each slice are N,Z,P.
- next_pc  out  PROGRAM_MEM_ADDR_BITS  PC of the next instruction.
- active_mask  out  THREADS  effective active lanes, equal to mask_reg & thread_enable.
- stack_depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_overflow  out  1  sticky error flag.

Behaviour:
- Reset values: next_pc=0, mask_reg=all ones, every nzp[t]=0, stack_depth=0, stack_overflow=0. Stack contents are don't-care. A reset mid-divergence discards the whole stack.
- All updates are registered with single-cycle latency and take effect only when enable=1.
- UPDATE state: if decoded_nzp_write_enable=1, each lane t with active_mask[t]=1 loads nzp[t] <= alu_out slice[2:0]. Inactive lanes keep their NZP value.
- EXECUTE state: take[t] = active_mask[t] & |(nzp[t] & decoded_nzp). Exactly one of the following cases applies.
- (a) decoded_pc_mux=0 and decoded_sync=0: next_pc <= next_pc+1.
- (b) pc_mux=1, take == active_mask, and active_mask != 0 (uniform taken): next_pc <= imm.
- (c) pc_mux=1 and take == 0 (uniform not-taken): next_pc <= next_pc+1.
- (d) pc_mux=1, divergent, and at least 2 free entries: push RECONV{mask=active_mask}, then push ELSE{pc=next_pc+1, mask=active_mask & ~take}. Set mask_reg <= take, next_pc <= imm, stack_depth += 2.
- (e) pc_mux=1, divergent, and fewer than 2 free entries: no push, stack_overflow <= 1, mask unchanged, next_pc <= next_pc+1.
- (f) decoded_sync=1 with a non-empty stack: pop the top entry.
  - ELSE entry: next_pc <= entry.pc, mask_reg <= entry.mask.
  - RECONV entry: mask_reg <= entry.mask, next_pc <= next_pc+1.
  - stack_depth -= 1.
- (g) decoded_sync=1 with an empty stack: next_pc <= next_pc+1, nothing else changes.
- If decoded_sync and decoded_pc_mux are both set, pc_mux has priority and sync is ignored.
- PC arithmetic wraps modulo 2^PROGRAM_MEM_ADDR_BITS, so 8'hFF+1 = 8'h00.
- Each stack entry holds {type, pc, mask}.
- Nesting works to STACK_DEPTH/2 levels. The else-path and the reconvergence path each end with their own SYNC.
- In states other than EXECUTE and UPDATE, all state holds.

Test Plan:
- Uniform branch: all 4 lanes CMP → nzp=3'b010; at pc=5 execute BRz imm=20 → next_pc=20, active_mask=4'hF, stack_depth=0. Repeat with BRp → next_pc=6.
- Divergence: lanes 0,1 have nzp=100 and lanes 2,3 have nzp=001; at pc=10 execute BRn imm=30 → next_pc=30, mask=4'b0011, depth=2. SYNC at 31 → next_pc=11, mask=4'b1100, depth=1. SYNC at 12 → next_pc=13, mask=4'hF, depth=0.
- Nested: inside the taken path with mask=4'b0011, diverge lane 0 vs lane 1 → depth=4. Four SYNCs unwind through masks 0001 → 0010 → 0011 → (outer else path) 1100, ending at 4'hF.
- Overflow: STACK_DEPTH=2; trigger a second divergence while depth=2 → stack_overflow=1, depth stays 2, next_pc=pc+1, and the flag stays set until reset.
- Masking and wrap: thread_enable=4'b0111 → active_mask=4'b0111, and a CMP leaves nzp[3] unchanged. Non-branch at pc=8'hFF → next_pc=0. enable=0 during EXECUTE → no change.
- Reset mid-operation: assert reset at depth=2 with mask=4'b0011 → next cycle next_pc=0, mask=4'hF, depth=0, all nzp=0.
